freelist: RTL and testbench

Physical-register free list for the R10K rename pipeline. It tracks which physical tags are free and hands up to `N` of them per cycle to dispatch/rename. Every cycle it takes freed previous-mappings (`Told`) from the retire stage. On a retire-time mispredict it reloads the whole availability bitmap from the restore mask that retire produces. It sits between dispatch (consumer of tags) and retire (producer of frees and restore state).

---
 rtl/freelist_pkg.sv | 13 +
 rtl/freelist_psel.sv | 35 +++
 rtl/freelist.sv | 123 ++++++++++++
 tb/tb_freelist.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freelist_pkg.sv
// rtl/freelist_pkg.sv - shared sizing constants for the rename free list
//
// Default geometry for the R10K rename pipeline: allocation lanes per
// cycle, physical register count, architectural register count, and
// the physical tag width derived from them.
package freelist_pkg;

    localparam int N_LANES          = 3;
    localparam int PHYS_REG_SZ_R10K = 64;
    localparam int ARCH_REG_SZ      = 32;
    localparam int PHYS_TAG         = $clog2(PHYS_REG_SZ_R10K);

endpackage

// File: rtl/freelist_psel.sv
// rtl/freelist_psel.sv - N-way lowest-set-bit selector over the availability bitmap
//
// Ports:
//   avail  in   P      availability bitmap
//   gnt    out  N x P  one-hot of the j-th lowest set bit (0 if none)
//   tags   out  N x TW encoded index of gnt[j] (0 if none)
module freelist_psel #(
    parameter int N  = 3,
    parameter int P  = 64,
    parameter int TW = $clog2(P)
) (
    input  logic [P-1:0]         avail,
    output logic [N-1:0][P-1:0]  gnt,
    output logic [N-1:0][TW-1:0] tags
);

    logic [P-1:0] remaining;

    always_comb begin
        remaining = avail;
        gnt       = '0;
        tags      = '0;
        for (int j = 0; j < N; j++) begin
            // Two's-complement trick isolates the lowest set bit.
            gnt[j] = remaining & (-remaining);
            for (int i = 0; i < P; i++) begin
                if (gnt[j][i]) begin
                    tags[j] = TW'(i);
                end
            end
            remaining = remaining & ~gnt[j];
        end
    end

endmodule

// File: rtl/freelist.sv
// rtl/freelist.sv - physical-register free list with multi-lane allocate, retire free and restore
//
// Ports:
//   clock            in   1            clock
//   reset_n          in   1            asynchronous active-low reset
//   alloc_req        in   N            per-lane tag request (lane 0 oldest)
//   alloc_tags       out  N x TAG      granted tag per lane (0 when not granted)
//   alloc_valid      out  N            lane granted this cycle
//   alloc_stall      out  1            requests exceed free tags; nothing granted
//   free_mask        in   PHYS_REGS    tags freed by retire (bit 0 ignored)
//   mispredict       in   1            load restore_mask into the bitmap
//   restore_mask     in   PHYS_REGS    availability bitmap to restore
//   free_count       out  CW           registered number of free tags
//   double_free_err  out  1            sticky: an already-free tag was freed
module freelist
    import freelist_pkg::*;
#(
    parameter int  N         = N_LANES,
    parameter int  PHYS_REGS = PHYS_REG_SZ_R10K,
    parameter int  ARCH_REGS = ARCH_REG_SZ,
    localparam int TW        = $clog2(PHYS_REGS),
    localparam int CW        = $clog2(PHYS_REGS + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N-1:0]          alloc_req,
    output logic [N-1:0][TW-1:0]  alloc_tags,
    output logic [N-1:0]          alloc_valid,
    output logic                  alloc_stall,
    input  logic [PHYS_REGS-1:0]  free_mask,
    input  logic                  mispredict,
    input  logic [PHYS_REGS-1:0]  restore_mask,
    output logic [CW-1:0]         free_count,
    output logic                  double_free_err
);

    localparam logic [PHYS_REGS-1:0] RESET_AVAIL = {PHYS_REGS{1'b1}} << ARCH_REGS;
    localparam logic [CW-1:0]        RESET_COUNT = CW'(PHYS_REGS - ARCH_REGS);

    logic [PHYS_REGS-1:0]        avail;
    logic [PHYS_REGS-1:0]        avail_next;
    logic [CW-1:0]               count_next;
    logic                        dfree_hit;
    logic [N-1:0][PHYS_REGS-1:0] sel_gnt;
    logic [N-1:0][TW-1:0]        sel_tags;
    logic [PHYS_REGS-1:0]        granted_bits;
    logic [CW-1:0]               req_cnt;
    logic [CW-1:0]               rank;
    logic                        stall;

    freelist_psel #(
        .N  (N),
        .P  (PHYS_REGS),
        .TW (TW)
    ) u_psel (
        .avail (avail),
        .gnt   (sel_gnt),
        .tags  (sel_tags)
    );

    // Requests are compacted onto selector slots: the rank-th requesting
    // lane takes the rank-th lowest free tag. The whole request is
    // all-or-nothing, so partial grants never happen.
    always_comb begin
        req_cnt      = '0;
        rank         = '0;
        granted_bits = '0;
        alloc_valid  = '0;
        alloc_tags   = '0;
        for (int k = 0; k < N; k++) begin
            req_cnt = req_cnt + CW'(alloc_req[k]);
        end
        stall = (req_cnt > free_count);
        for (int k = 0; k < N; k++) begin
            if (alloc_req[k] && !stall) begin
                alloc_valid[k] = 1'b1;
                for (int j = 0; j < N; j++) begin
                    if (CW'(j) == rank) begin
                        alloc_tags[k] = sel_tags[j];
                        granted_bits  = granted_bits | sel_gnt[j];
                    end
                end
            end
            if (alloc_req[k]) begin
                rank = rank + 1'b1;
            end
        end
        alloc_stall = stall;
    end

    // Restore wins over allocate and free. The count is recomputed from the
    // next bitmap so it tracks the bitmap exactly even across a double free.
    always_comb begin
        if (mispredict) begin
            avail_next = restore_mask;
        end else begin
            avail_next = (avail & ~granted_bits) | free_mask;
        end
        avail_next[0] = 1'b0;

        count_next = '0;
        for (int i = 0; i < PHYS_REGS; i++) begin
            count_next = count_next + CW'(avail_next[i]);
        end

        dfree_hit = !mispredict && (|(free_mask[PHYS_REGS-1:1] & avail[PHYS_REGS-1:1]));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avail           <= RESET_AVAIL;
            free_count      <= RESET_COUNT;
            double_free_err <= 1'b0;
        end else begin
            avail      <= avail_next;
            free_count <= count_next;
            if (dfree_hit) begin
                double_free_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freelist.sv
// tb/tb_freelist.sv - self-checking bench for freelist with directed scenarios and random stimulus
module tb_freelist;

    localparam int N  = 3;
    localparam int P  = 64;
    localparam int A  = 32;
    localparam int TW = 6;
    localparam int CW = 7;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [N-1:0]         alloc_req;
    logic [N-1:0][TW-1:0] alloc_tags;
    logic [N-1:0]         alloc_valid;
    logic                 alloc_stall;
    logic [P-1:0]         free_mask;
    logic                 mispredict;
    logic [P-1:0]         restore_mask;
    logic [CW-1:0]        free_count;
    logic                 double_free_err;

    int checks   = 0;
    int failures = 0;

    logic [P-1:0]         m_avail;
    logic                 m_err;
    logic [N-1:0][TW-1:0] e_tags;
    logic [N-1:0]         e_valid;
    logic                 e_stall;
    logic [P-1:0]         e_granted;
    logic [N-1:0][TW-1:0] obs_tags;
    logic [N-1:0]         obs_valid;
    logic                 obs_stall;

    freelist #(.N(N), .PHYS_REGS(P), .ARCH_REGS(A)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .alloc_req       (alloc_req),
        .alloc_tags      (alloc_tags),
        .alloc_valid     (alloc_valid),
        .alloc_stall     (alloc_stall),
        .free_mask       (free_mask),
        .mispredict      (mispredict),
        .restore_mask    (restore_mask),
        .free_count      (free_count),
        .double_free_err (double_free_err)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_avail = '0;
        for (int i = A; i < P; i++) m_avail[i] = 1'b1;
        m_err = 1'b0;
    endtask

    // Expected grants: list free tags in ascending order and hand them out
    // to requesting lanes in lane order, all or nothing.
    task automatic model_predict(input logic [N-1:0] req);
        int freeq[$];
        int j;
        freeq = {};
        for (int i = 0; i < P; i++) if (m_avail[i]) freeq.push_back(i);
        e_tags    = '0;
        e_valid   = '0;
        e_granted = '0;
        e_stall   = ($countones(req) > freeq.size());
        if (!e_stall) begin
            j = 0;
            for (int k = 0; k < N; k++) begin
                if (req[k]) begin
                    e_tags[k]           = TW'(freeq[j]);
                    e_valid[k]          = 1'b1;
                    e_granted[freeq[j]] = 1'b1;
                    j++;
                end
            end
        end
    endtask

    // Called at a negedge: apply inputs, capture combinational outputs,
    // clock once, advance the model, return at the next negedge.
    task automatic drive(input logic [N-1:0] req, input logic [P-1:0] fm,
                         input logic mp, input logic [P-1:0] rm);
        alloc_req    = req;
        free_mask    = fm;
        mispredict   = mp;
        restore_mask = rm;
        #1;
        obs_tags  = alloc_tags;
        obs_valid = alloc_valid;
        obs_stall = alloc_stall;
        model_predict(req);
        @(posedge clock);
        if (mp) begin
            m_avail = rm;
        end else begin
            if (|(fm & m_avail & ~64'd1)) m_err = 1'b1;
            m_avail = (m_avail & ~e_granted) | fm;
        end
        m_avail[0] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        alloc_req    = '0;
        free_mask    = '0;
        mispredict   = 1'b0;
        restore_mask = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);
        checks++; if (free_count !== CW'(32)) begin failures++; $display("FAIL reset_count got=%0d exp=32", free_count); end
        checks++; if (alloc_valid !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", alloc_valid); end
        checks++; if (double_free_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", double_free_err); end
        checks++; if (alloc_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", alloc_stall); end
    endtask

    task automatic test_sparse();
        drive(3'b101, '0, 1'b0, '0);
        checks++; if (obs_valid !== 3'b101) begin failures++; $display("FAIL sparse_valid got=%b exp=101", obs_valid); end
        checks++; if (obs_tags[0] !== 6'd32 || obs_tags[2] !== 6'd33 || obs_tags[1] !== 6'd0) begin
            failures++; $display("FAIL sparse_tags got=%0d,%0d,%0d exp=32,0,33", obs_tags[0], obs_tags[1], obs_tags[2]);
        end
        checks++; if (free_count !== CW'(30)) begin failures++; $display("FAIL sparse_count got=%0d exp=30", free_count); end
        drive(3'b001, '0, 1'b0, '0);
        checks++; if (obs_valid !== 3'b001 || obs_tags[0] !== 6'd34) begin
            failures++; $display("FAIL sparse_next got=%b/%0d exp=001/34", obs_valid, obs_tags[0]);
        end
    endtask

    task automatic test_exhaustion();
        while ($countones(m_avail) > 2) begin
            if ($countones(m_avail) >= 5) drive(3'b111, '0, 1'b0, '0);
            else drive(3'b001, '0, 1'b0, '0);
        end
        checks++; if (free_count !== CW'(2)) begin failures++; $display("FAIL drain_count got=%0d exp=2", free_count); end
        drive(3'b111, '0, 1'b0, '0);
        checks++; if (obs_stall !== 1'b1 || obs_valid !== 3'b000) begin
            failures++; $display("FAIL exhaust_stall got=%b/%b exp=1/000", obs_stall, obs_valid);
        end
        checks++; if (free_count !== CW'(2)) begin failures++; $display("FAIL exhaust_hold got=%0d exp=2", free_count); end
        drive(3'b011, '0, 1'b0, '0);
        checks++; if (obs_valid !== 3'b011 || obs_tags[0] !== 6'd62 || obs_tags[1] !== 6'd63) begin
            failures++; $display("FAIL exhaust_last got=%b/%0d,%0d exp=011/62,63", obs_valid, obs_tags[0], obs_tags[1]);
        end
        checks++; if (free_count !== CW'(0)) begin failures++; $display("FAIL exhaust_empty got=%0d exp=0", free_count); end
    endtask

    task automatic test_free_alloc();
        logic [P-1:0] fm;
        fm = '0; fm[40] = 1'b1;
        drive(3'b001, fm, 1'b0, '0);
        checks++; if (obs_stall !== 1'b1 || obs_valid !== 3'b000) begin
            failures++; $display("FAIL nobypass got=%b/%b exp=1/000", obs_stall, obs_valid);
        end
        checks++; if (free_count !== CW'(1)) begin failures++; $display("FAIL freed_count got=%0d exp=1", free_count); end
        drive(3'b001, '0, 1'b0, '0);
        checks++; if (obs_valid !== 3'b001 || obs_tags[0] !== 6'd40) begin
            failures++; $display("FAIL freed_grant got=%b/%0d exp=001/40", obs_valid, obs_tags[0]);
        end
        checks++; if (double_free_err !== 1'b0) begin failures++; $display("FAIL no_err got=%b exp=0", double_free_err); end
    endtask

    task automatic test_mispredict();
        logic [P-1:0] fm;
        logic [P-1:0] rm;
        fm = '0; fm[50] = 1'b1;
        rm = '0; rm[0] = 1'b1;
        for (int i = 32; i <= 47; i++) rm[i] = 1'b1;
        drive(3'b111, fm, 1'b1, rm);
        checks++; if (free_count !== CW'(16)) begin failures++; $display("FAIL restore_count got=%0d exp=16", free_count); end
        drive(3'b001, '0, 1'b0, '0);
        checks++; if (obs_valid !== 3'b001 || obs_tags[0] !== 6'd32) begin
            failures++; $display("FAIL restore_first got=%b/%0d exp=001/32", obs_valid, obs_tags[0]);
        end
        checks++; if (free_count !== CW'(15)) begin failures++; $display("FAIL restore_after got=%0d exp=15", free_count); end
    endtask

    task automatic test_double_free();
        logic [P-1:0] fm;
        fm = '0; fm[33] = 1'b1;
        drive(3'b000, fm, 1'b0, '0);
        checks++; if (double_free_err !== 1'b1) begin failures++; $display("FAIL dfree_set got=%b exp=1", double_free_err); end
        checks++; if (free_count !== CW'(15)) begin failures++; $display("FAIL dfree_count got=%0d exp=15", free_count); end
        repeat (3) drive(3'b001, '0, 1'b0, '0);
        checks++; if (double_free_err !== 1'b1) begin failures++; $display("FAIL dfree_sticky got=%b exp=1", double_free_err); end
        // Asynchronous reset pulse between clock edges.
        alloc_req = '0; free_mask = '0; mispredict = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (free_count !== CW'(32)) begin failures++; $display("FAIL async_count got=%0d exp=32", free_count); end
        checks++; if (double_free_err !== 1'b0) begin failures++; $display("FAIL async_err got=%b exp=0", double_free_err); end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        drive(3'b001, '0, 1'b0, '0);
        checks++; if (obs_valid !== 3'b001 || obs_tags[0] !== 6'd32) begin
            failures++; $display("FAIL async_grant got=%b/%0d exp=001/32", obs_valid, obs_tags[0]);
        end
    endtask

    task automatic test_random();
        logic [P-1:0] fm;
        logic [P-1:0] rm;
        logic         mp;
        int           t;
        for (int c = 0; c < 400; c++) begin
            fm = '0;
            for (int f = 0; f < 3; f++) begin
                t = $urandom_range(0, P - 1);
                if (!m_avail[t] || ($urandom_range(0, 40) == 0)) fm[t] = 1'b1;
            end
            mp = ($urandom_range(0, 30) == 0);
            rm = {$urandom, $urandom};
            drive(N'($urandom_range(0, 7)), fm, mp, rm);
            checks++; if (obs_stall !== e_stall || obs_valid !== e_valid || obs_tags !== e_tags) begin
                failures++; $display("FAIL rand_grant cyc=%0d got=%b/%b/%h exp=%b/%b/%h", c, obs_stall, obs_valid, obs_tags, e_stall, e_valid, e_tags);
            end
            checks++; if (free_count !== CW'($countones(m_avail))) begin
                failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, free_count, $countones(m_avail));
            end
            checks++; if (double_free_err !== m_err) begin
                failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, double_free_err, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_exhaustion();
        test_free_alloc();
        test_mispredict();
        test_double_free();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
